register_bank_dumper: RTL

- Debug-side reader for the 32x32 register bank: on a start pulse, reads registers 0..BANK_DEPTH-1 in order through a spare read port.
- Serializes each word LSB-byte-first onto a byte stream with a valid/ready handshake toward the debug UART transmitter.
- Sits between registers_bank and the debug unit's UART TX. It is used only while the pipeline is halted.

---
 rtl/register_bank_dumper_pkg.sv | 33 +++
 rtl/register_bank_dumper_word_serializer.sv | 58 +++++
 rtl/register_bank_dumper.sv | 105 ++++++++++
 3 files changed

// File: rtl/register_bank_dumper_pkg.sv
// Shared definitions for the register bank dumper: default widths, FSM
// state encoding and a constant-evaluable ceil(log2) helper.
package register_bank_dumper_pkg;

    localparam int unsigned NB_DATA_DEF    = 32;
    localparam int unsigned NB_ADDR_DEF    = 5;
    localparam int unsigned BANK_DEPTH_DEF = 32;
    localparam int unsigned NB_BYTE_DEF    = 8;
    localparam int unsigned BYTES_PER_WORD = NB_DATA_DEF / NB_BYTE_DEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Smallest n such that 2**n >= value (0 for value <= 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        for (int i = 0; i < 32; i++) begin
            if (span < value) begin
                span   = span << 1;
                result = result + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/register_bank_dumper_word_serializer.sv
// Word-to-byte serializer: loads a word, presents its low byte with valid,
// shifts one byte out per valid/ready transfer and flags the last byte.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         capture load_data and restart the byte count
//   load_data    word to serialize
//   send         byte stream is active (drives tx_valid)
//   ready        downstream accepts the byte this cycle
//   tx_data      current byte (low byte of the shift register)
//   tx_valid     tx_data is valid
//   last_byte_c  combinational: final byte of the word transfers this cycle
module register_bank_dumper_word_serializer
    import register_bank_dumper_pkg::*;
#(
    parameter int unsigned NB_DATA = NB_DATA_DEF,
    parameter int unsigned NB_BYTE = NB_BYTE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [NB_DATA-1:0] load_data,
    input  logic               send,
    input  logic               ready,
    output logic [NB_BYTE-1:0] tx_data,
    output logic               tx_valid,
    output logic               last_byte_c
);

    localparam int unsigned BPW    = NB_DATA / NB_BYTE;
    localparam int unsigned NB_CNT = (clog2(BPW) > 0) ? clog2(BPW) : 1;
    localparam logic [NB_CNT-1:0] LAST_CNT = NB_CNT'(BPW - 1);

    logic [NB_DATA-1:0] shift;
    logic [NB_CNT-1:0]  count;
    logic               xfer_c;

    assign xfer_c = send && ready;

    // Shift register and byte counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift <= '0;
            count <= '0;
        end else if (load) begin
            shift <= load_data;
            count <= '0;
        end else if (xfer_c) begin
            shift <= shift >> NB_BYTE;
            count <= count + NB_CNT'(1);
        end
    end

    // Valid is purely a function of the FSM state, never of ready.
    assign tx_data     = shift[NB_BYTE-1:0];
    assign tx_valid    = send;
    assign last_byte_c = xfer_c && (count == LAST_CNT);

endmodule

// File: rtl/register_bank_dumper.sv
// Debug-side register bank dumper: on i_start, reads registers
// 0..BANK_DEPTH-1 through a spare read port and streams each word
// LSB byte first over a valid/ready byte interface.
// Ports:
//   i_clock, i_reset  clock, asynchronous active-low reset
//   i_start           dump request, honoured only in IDLE
//   o_read_reg        register-bank read address (current register index)
//   i_read_data       register-bank read data, combinational in o_read_reg
//   o_tx_data/valid   byte stream toward the UART transmitter
//   i_tx_ready        transmitter accepts the byte this cycle
//   o_busy            dump in progress (READ/SEND/DONE)
//   o_done            one-cycle pulse after the final byte transfers
module register_bank_dumper
    import register_bank_dumper_pkg::*;
#(
    parameter int unsigned NB_DATA    = NB_DATA_DEF,
    parameter int unsigned NB_ADDR    = NB_ADDR_DEF,
    parameter int unsigned BANK_DEPTH = BANK_DEPTH_DEF,
    parameter int unsigned NB_BYTE    = NB_BYTE_DEF
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    output logic [NB_ADDR-1:0] o_read_reg,
    input  logic [NB_DATA-1:0] i_read_data,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic [NB_ADDR-1:0] LAST_REG = NB_ADDR'(BANK_DEPTH - 1);

    state_t             state;
    state_t             state_next;
    logic [NB_ADDR-1:0] reg_idx;
    logic [NB_ADDR-1:0] reg_idx_next;
    logic               last_byte_c;

    // State and register index.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state   <= ST_IDLE;
            reg_idx <= '0;
        end else begin
            state   <= state_next;
            reg_idx <= reg_idx_next;
        end
    end

    // Next-state logic; the index only advances after a word's last byte.
    always_comb begin
        state_next   = state;
        reg_idx_next = reg_idx;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_next   = ST_READ;
                    reg_idx_next = '0;
                end
            end
            ST_READ: begin
                state_next = ST_SEND;
            end
            ST_SEND: begin
                if (last_byte_c) begin
                    if (reg_idx == LAST_REG) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next   = ST_READ;
                        reg_idx_next = reg_idx + NB_ADDR'(1);
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    register_bank_dumper_word_serializer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_serializer (
        .clk         (i_clock),
        .rst_n       (i_reset),
        .load        (state == ST_READ),
        .load_data   (i_read_data),
        .send        (state == ST_SEND),
        .ready       (i_tx_ready),
        .tx_data     (o_tx_data),
        .tx_valid    (o_tx_valid),
        .last_byte_c (last_byte_c)
    );

    // Outputs decoded from registered state and fields only.
    assign o_read_reg = reg_idx;
    assign o_busy     = (state != ST_IDLE);
    assign o_done     = (state == ST_DONE);

endmodule
